// File: rtl/cp0_exc_ctrl_if.sv
// Commit-slot and CP0 event bus between the commit stage / CP0 register file
// (master) and the exception controller (slave).
interface cp0_exc_ctrl_if;
  logic [31:0] cp0_Status_data;
  logic [1:0]  cp0_Cause_ip_sw;
  logic [5:0]  hw_int;
  logic [31:0] cp0_EPC_data;
  logic        cmt_valid;
  logic        cmt_exc;
  logic [4:0]  cmt_excode;
  logic [31:0] cmt_pc;
  logic        cmt_is_bd;
  logic [31:0] cmt_badvaddr;
  logic        cmt_eret;
  logic        cmt_accept;
  logic        exception;
  logic        eret_op;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic        badvaddr_we;
  logic [31:0] badvaddr_data;
  logic [5:0]  cause_ip_hw;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output cp0_Status_data, cp0_Cause_ip_sw, hw_int, cp0_EPC_data,
           cmt_valid, cmt_exc, cmt_excode, cmt_pc, cmt_is_bd, cmt_badvaddr, cmt_eret,
    input  cmt_accept, exception, eret_op, exc_excode, exc_bd, exc_epc,
           badvaddr_we, badvaddr_data, cause_ip_hw, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  cp0_Status_data, cp0_Cause_ip_sw, hw_int, cp0_EPC_data,
           cmt_valid, cmt_exc, cmt_excode, cmt_pc, cmt_is_bd, cmt_badvaddr, cmt_eret,
    output cmt_accept, exception, eret_op, exc_excode, exc_bd, exc_epc,
           badvaddr_we, badvaddr_data, cause_ip_hw, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt/ERET arbiter: selects one event per commit slot,
// pulses the CP0 update strobes, then sequences flush and fetch redirect.
module cp0_exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter logic [31:0] EXC_VECTOR_NB = 32'h80000180
) (
  input logic           clk,
  input logic           rst,
  cp0_exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  sync1_q, sync2_q;
  logic        exception_q, exception_d;
  logic        eret_op_q, eret_op_d;
  logic [4:0]  excode_q, excode_d;
  logic        exc_bd_q, exc_bd_d;
  logic [31:0] epc_q, epc_d;
  logic        bv_we_q, bv_we_d;
  logic [31:0] bv_data_q, bv_data_d;
  logic [31:0] target_q, target_d;

  logic [7:0]  ip;
  logic        int_pend;
  logic        accept;
  logic        take_exc;
  logic [4:0]  sel_code;
  logic        status_unused;

  assign status_unused = &{bus.cp0_Status_data[31:23], bus.cp0_Status_data[21:16],
                           bus.cp0_Status_data[7:2]};

  assign ip       = {sync2_q, bus.cp0_Cause_ip_sw};
  assign int_pend = bus.cp0_Status_data[0] & ~bus.cp0_Status_data[1]
                  & |(bus.cp0_Status_data[15:8] & ip);
  // Gated by rst so that every output reads 0 while reset is held.
  assign accept   = bus.cmt_valid & (state_q == ST_IDLE) & ~rst;
  assign take_exc = int_pend | bus.cmt_exc;
  assign sel_code = int_pend ? 5'd0 : bus.cmt_excode;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exception_d = 1'b0;
    eret_op_d   = 1'b0;
    bv_we_d     = 1'b0;
    excode_d    = excode_q;
    exc_bd_d    = exc_bd_q;
    epc_d       = epc_q;
    bv_data_d   = bv_data_q;
    target_d    = target_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (take_exc || bus.cmt_eret)) begin
          state_d = ST_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
          if (take_exc) begin
            exception_d = 1'b1;
            excode_d    = sel_code;
            exc_bd_d    = bus.cmt_is_bd;
            epc_d       = bus.cmt_is_bd ? bus.cmt_pc - 32'd4 : bus.cmt_pc;
            bv_we_d     = (sel_code == 5'd4) || (sel_code == 5'd5);
            bv_data_d   = bus.cmt_badvaddr;
            target_d    = bus.cp0_Status_data[22] ? EXC_VECTOR : EXC_VECTOR_NB;
          end else begin
            eret_op_d = 1'b1;
            target_d  = bus.cp0_EPC_data;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      exception_q <= 1'b0;
      eret_op_q   <= 1'b0;
      excode_q    <= '0;
      exc_bd_q    <= 1'b0;
      epc_q       <= '0;
      bv_we_q     <= 1'b0;
      bv_data_q   <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= bus.hw_int;
      sync2_q     <= sync1_q;
      exception_q <= exception_d;
      eret_op_q   <= eret_op_d;
      excode_q    <= excode_d;
      exc_bd_q    <= exc_bd_d;
      epc_q       <= epc_d;
      bv_we_q     <= bv_we_d;
      bv_data_q   <= bv_data_d;
      target_q    <= target_d;
    end
  end

  assign bus.cmt_accept     = accept;
  assign bus.exception      = exception_q;
  assign bus.eret_op        = eret_op_q;
  assign bus.exc_excode     = excode_q;
  assign bus.exc_bd         = exc_bd_q;
  assign bus.exc_epc        = epc_q;
  assign bus.badvaddr_we    = bv_we_q;
  assign bus.badvaddr_data  = bv_data_q;
  assign bus.cause_ip_hw    = sync2_q;
  assign bus.flush          = (state_q == ST_FLUSH);
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.redirect_pc    = (state_q == ST_REDIRECT) ? target_q : '0;

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Consumer side of the CP0 Status/Cause interface. Reads the live Status word (IE, EXL, IM, Bev) and the pending-interrupt lines.
- Picks one exception, interrupt or ERET per commit slot and produces the `exception`/`eret_op` pulses that the Status, Cause and EPC registers consume.
- Sequences the pipeline flush and the PC redirect.
- Sits between the writeback/commit stage and the CP0 register file.

Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after an event (1..15).
- EXC_VECTOR, 32'hBFC00380, handler address used while Status.Bev=1.
- EXC_VECTOR_NB, 32'h80000180, handler address used while Status.Bev=0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cp0_Status_data  in  32  current Status word: IE=bit0, EXL=bit1, IM=bits15:8, Bev=bit22
- cp0_Cause_ip_sw  in  2  Cause.IP[1:0] software interrupt bits
- hw_int  in  6  asynchronous hardware interrupt lines
- cp0_EPC_data  in  32  current EPC, used as the ERET target
- cmt_valid  in  1  an instruction is at the commit point this cycle
- cmt_exc  in  1  the committing instruction carries a synchronous exception
- cmt_excode  in  5  ExcCode of that exception
- cmt_pc  in  32  PC of the committing instruction
- cmt_is_bd  in  1  the committing instruction is in a branch delay slot
- cmt_badvaddr  in  32  faulting address, valid for ExcCode 4 and 5
- cmt_eret  in  1  the committing instruction is ERET
- cmt_accept  out  1  commit slot is accepted this cycle
- exception  out  1  one-cycle pulse to Status/Cause/EPC
- eret_op  out  1  one-cycle pulse to Status
- exc_excode  out  5  ExcCode written to Cause
- exc_bd  out  1  value written to Cause.BD
- exc_epc  out  32  value written to EPC
- badvaddr_we  out  1  BadVAddr write enable, asserted with `exception`
- badvaddr_data  out  32  value written to BadVAddr
- cause_ip_hw  out  6  synchronised hardware IP, feeds Cause.IP[7:2]
- flush  out  1  pipeline flush
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE.
  - All outputs are 0, including the synchronisers and counters.
- Interrupt synchronisation:
  - hw_int passes through a 2-flop synchroniser; the second stage drives cause_ip_hw.
  - Latency from a hw_int edge to cause_ip_hw is 2 cycles.
- Interrupt pending:
  - ip = {cause_ip_hw, cp0_Cause_ip_sw}.
  - int_pend = IE & ~EXL & |(IM & ip). It is combinational on the current inputs.
- cmt_accept = cmt_valid & (state==IDLE). Commits are refused in every other state, and the commit stage holds them.
- Priority on an accepted commit, highest first:
  1. int_pend: excode=0, attached to the committing instruction.
  2. cmt_exc: excode=cmt_excode.
  3. cmt_eret.
  4. Otherwise a plain commit, with no action.
- Exception event:
  - Next cycle: exception=1 for exactly 1 cycle.
  - Registered with it: exc_excode, exc_bd=cmt_is_bd, and exc_epc = cmt_is_bd ? cmt_pc-4 : cmt_pc (32-bit wrap).
  - badvaddr_we=1 only when excode is 4 or 5; otherwise 0. badvaddr_data=cmt_badvaddr.
  - Target = Bev ? EXC_VECTOR : EXC_VECTOR_NB, sampled at the accept cycle.
- ERET event:
  - Next cycle: eret_op=1 for exactly 1 cycle.
  - Target = cp0_EPC_data, sampled at the accept cycle.
  - When int_pend and cmt_eret are both true, the interrupt wins and eret_op stays 0.
- ERET while EXL=0 is still performed. No exception is raised.
- FSM:
  - IDLE -> FLUSH on an exception or ERET event. The counter loads FLUSH_CYCLES-1.
  - FLUSH: flush=1 and the counter decrements. Leave when the counter is 0.
  - FLUSH -> REDIRECT: redirect_valid=1 and redirect_pc=target for 1 cycle.
  - REDIRECT -> IDLE.
- flush goes high in the same cycle as the exception/eret_op pulse and stays high for exactly FLUSH_CYCLES cycles. redirect_valid follows in the next cycle.
- The total blocked window is FLUSH_CYCLES+1 cycles after the accept.
- An interrupt that arrives during FLUSH or REDIRECT is not lost. It is evaluated at the next accepted commit, and only if still pending under the Status then current.
- An rst assertion mid-sequence aborts immediately. No redirect_valid follows.

Test Plan:
- Status=0x0040FF01 (IE=1, Bev=1, IM=FF), hw_int[2] rises, cmt_valid=1 at PC 0x80001000 -> cause_ip_hw[2]=1 after 2 cycles. The next accepted commit gives:
  - exception pulse, excode=0, exc_epc=0x80001000
  - flush high for 2 cycles
  - redirect_pc=0xBFC00380
- Status EXL=1 with hw_int asserted -> no exception. Commits are accepted every cycle.
- cmt_exc=1, excode=4, cmt_is_bd=1, pc=0x80002004, badvaddr=0x00000003 -> exc_epc=0x80002000, exc_bd=1, badvaddr_we=1 with data 0x3.
- cmt_eret=1, EPC=0x80003000, no interrupt pending -> eret_op pulse, exception=0, redirect to 0x80003000 on cycle accept+3.
- cmt_eret=1 with int_pend=1 -> exception with excode=0, eret_op stays 0.
- rst pulsed during FLUSH -> all outputs 0 immediately, no redirect_valid follows, and the next commit is accepted normally.
